// File: rtl/data_mem_pkg.sv
// Shared widths and encodings for the block-level main-memory model.
package data_mem_pkg;

  localparam int BLOCK_W      = 128;
  localparam int BLOCK_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/data_memory_array.sv
// Block storage: synchronous write, asynchronous read, no reset (contents survive RESET).
module data_memory_array
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  CLK,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [BLOCK_W-1:0]    wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [BLOCK_W-1:0]    rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [BLOCK_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_memory.sv
// Fixed-latency main memory behind the data cache: IDLE/BUSY/DONE handshake with
// combinational busywait, latched request, and registered read data.
module data_memory
  import data_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 5
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    MEM_READ,
  input  logic                    MEM_WRITE,
  input  logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]      MEM_WRITEDATA,
  output logic [BLOCK_W-1:0]      MEM_READDATA,
  output logic                    MEM_BUSYWAIT
);

  if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
    $error("data_memory: LATENCY must be within 2..15");
  end

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [BLOCK_W-1:0]      wdata_q, wdata_d;
  logic [BLOCK_W-1:0]      rdata_q, rdata_d;
  op_e                     op_q, op_d;
  logic                    req;
  logic                    mem_we;
  logic                    busy;
  logic [BLOCK_W-1:0]      arr_rdata;

  // Upper address bits alias onto the same blocks.
  logic unused_addr_hi;
  assign unused_addr_hi = ^MEM_ADDRESS[BLOCK_ADDR_W-1:DEPTH_LOG2];

  assign req = MEM_READ | MEM_WRITE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    busy    = 1'b0;

    case (state_q)
      IDLE: begin
        busy = req;
        if (req) begin
          addr_d  = MEM_ADDRESS[DEPTH_LOG2-1:0];
          wdata_d = MEM_WRITEDATA;
          op_d    = MEM_WRITE ? OP_WRITE : OP_READ;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end

      BUSY: begin
        busy = 1'b1;
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          if (op_q == OP_WRITE) begin
            mem_we = ~RESET;
          end else begin
            rdata_d = arr_rdata;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        // Any request still asserted here belongs to the finished transaction.
        busy    = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
    end
  end

  data_memory_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .CLK     (CLK),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_o (arr_rdata)
  );

  assign MEM_READDATA = rdata_q;
  assign MEM_BUSYWAIT = busy;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: handshake timing, write/read, back-to-back, abort, alias, reset.
module tb_data_memory;

  logic         CLK;
  logic         RESET;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] DA = 128'hAAAA0000_11112222_33334444_55556666;
  localparam logic [127:0] DB = 128'hBBBBBBBB_01020304_05060708_090A0B0C;
  localparam logic [127:0] DC = 128'hCCCCCCCC_DEADBEEF_CAFEF00D_12345678;

  data_memory #(
    .DEPTH_LOG2(8),
    .LATENCY   (5)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request just after an edge; that cycle is C0 of the transaction.
  task automatic start(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] data);
    @(posedge CLK);
    #1;
    MEM_READ      = rd;
    MEM_WRITE     = wr;
    MEM_ADDRESS   = addr;
    MEM_WRITEDATA = data;
  endtask

  // Count busy cycles from the current cycle; returns at the negedge of the first non-busy cycle.
  task automatic wait_done(output int n);
    n = 0;
    @(negedge CLK);
    while (MEM_BUSYWAIT === 1'b1 && n < 40) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic go_idle();
    @(posedge CLK);
    #1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
  endtask

  initial begin
    int n;

    RESET         = 1'b1;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_rdata", MEM_READDATA, 128'd0);
    chk("reset_busy", 128'(MEM_BUSYWAIT), 128'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Read after reset
    start(1'b1, 1'b0, 28'h0000012, 128'd0);
    wait_done(n);
    chk("rd12_busy_cycles", 128'(n), 128'd5);
    chk("rd12_rdata", MEM_READDATA, 128'd0);
    go_idle();
    @(negedge CLK);
    chk("idle_busy_low", 128'(MEM_BUSYWAIT), 128'd0);

    // Write then read
    start(1'b0, 1'b1, 28'h0000034, D1);
    wait_done(n);
    chk("wr34_busy_cycles", 128'(n), 128'd5);
    go_idle();
    start(1'b1, 1'b0, 28'h0000034, 128'd0);
    wait_done(n);
    chk("rd34_busy_cycles", 128'(n), 128'd5);
    chk("rd34_rdata", MEM_READDATA, D1);
    go_idle();

    // Back-to-back write-back then refill
    start(1'b0, 1'b1, 28'h0000040, DA);
    wait_done(n);
    chk("wr40_busy_cycles", 128'(n), 128'd5);
    start(1'b1, 1'b0, 28'h0000050, 128'd0);
    @(negedge CLK);
    chk("b2b_first_cycle_busy", 128'(MEM_BUSYWAIT), 128'd1);
    wait_done(n);
    chk("b2b_rest_busy_cycles", 128'(n), 128'd4);
    chk("rd50_rdata", MEM_READDATA, 128'd0);
    go_idle();
    start(1'b1, 1'b0, 28'h0000040, 128'd0);
    wait_done(n);
    chk("rd40_rdata", MEM_READDATA, DA);
    go_idle();

    // Abort a write after two busy cycles in BUSY
    start(1'b0, 1'b1, 28'h0000060, DB);
    repeat (3) @(posedge CLK);
    #1;
    MEM_WRITE = 1'b0;
    @(negedge CLK);
    chk("abort_still_busy", 128'(MEM_BUSYWAIT), 128'd1);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("abort_idle_busy", 128'(MEM_BUSYWAIT), 128'd0);
    chk("abort_rdata_held", MEM_READDATA, DA);
    start(1'b1, 1'b0, 28'h0000060, 128'd0);
    wait_done(n);
    chk("rd60_not_committed", MEM_READDATA, 128'd0);
    go_idle();

    // Read+write together is a write; upper address bits alias
    start(1'b1, 1'b1, 28'h0000170, DC);
    wait_done(n);
    chk("prio_busy_cycles", 128'(n), 128'd5);
    chk("prio_rdata_unchanged", MEM_READDATA, 128'd0);
    go_idle();
    start(1'b1, 1'b0, 28'h0000070, 128'd0);
    wait_done(n);
    chk("rd70_alias", MEM_READDATA, DC);
    go_idle();

    // Reset during a read, request kept asserted across it
    start(1'b1, 1'b0, 28'h0000034, 128'd0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("rst_mid_rdata", MEM_READDATA, 128'd0);
    chk("rst_mid_busy_tracks_req", 128'(MEM_BUSYWAIT), 128'd1);
    wait_done(n);
    chk("rst_mid_rest_busy_cycles", 128'(n), 128'd4);
    chk("rst_mid_storage_intact", MEM_READDATA, D1);
    go_idle();
    @(negedge CLK);
    chk("final_idle_busy", 128'(MEM_BUSYWAIT), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
